// File: rtl/gimli_lwc_pkg.sv
// Shared constants and helpers for the Gimli LWC datapath blocks.
// Handshake widths and the default datapath geometry live here.
package gimli_lwc_pkg;

   localparam int C_DATA_W     = 32;
   localparam int C_FIFO_DEPTH = 4;

   // Ceiling log2, evaluated at elaboration; clog2(1) = 0.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/gimli_lwc_fifo_mem.sv
// Register-array storage for the output FIFO: one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module gimli_lwc_fifo_mem
   import gimli_lwc_pkg::*;
#(
   parameter int G_WIDTH = C_DATA_W,
   parameter int G_DEPTH = C_FIFO_DEPTH,
   localparam int A_W = clog2(G_DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [A_W-1:0]   wr_addr,
   input  logic [G_WIDTH:0] wr_data,
   input  logic [A_W-1:0]   rd_addr,
   output logic [G_WIDTH:0] rd_data
);

   logic [G_WIDTH:0] mem_reg [G_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/gimli_lwc_fifo_out.sv
// Multi-entry {last, data} output FIFO between the Gimli core and the LWC
// output port, with occupancy, complete-message count and synchronous flush.
module gimli_lwc_fifo_out
   import gimli_lwc_pkg::*;
#(
   parameter int G_WIDTH = C_DATA_W,
   parameter int G_DEPTH = C_FIFO_DEPTH,
   localparam int G_CNT_W = clog2(G_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [G_WIDTH-1:0] din,
   input  logic               din_last,
   input  logic               din_valid,
   output logic               din_ready,
   output logic [G_WIDTH-1:0] dout,
   output logic               dout_last,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic [G_CNT_W-1:0] count,
   output logic [G_CNT_W-1:0] msg_count,
   output logic               msg_avail
);

   localparam int PTR_W = clog2(G_DEPTH);

   logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [G_CNT_W-1:0] count_reg, count_next;
   logic [G_CNT_W-1:0] msg_count_reg, msg_count_next;
   logic               full, empty, wr, rd;
   logic [G_WIDTH:0]   head;

   assign full  = (count_reg == G_CNT_W'(G_DEPTH));
   assign empty = (count_reg == '0);

   // When full, a write is only taken alongside a read of the head word.
   assign din_ready  = ~full | dout_ready;
   assign dout_valid = ~empty;
   assign wr = din_valid & din_ready;
   assign rd = dout_valid & dout_ready;

   gimli_lwc_fifo_mem #(
      .G_WIDTH (G_WIDTH),
      .G_DEPTH (G_DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr & ~rst & ~flush),
      .wr_addr (wr_ptr_reg),
      .wr_data ({din_last, din}),
      .rd_addr (rd_ptr_reg),
      .rd_data (head)
   );

   // Storage is never cleared, so mask the head word while empty.
   assign dout      = empty ? '0 : head[G_WIDTH-1:0];
   assign dout_last = ~empty & head[G_WIDTH];

   always_comb begin
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      count_next     = count_reg;
      msg_count_next = msg_count_reg;
      if (rst | flush) begin
         wr_ptr_next    = '0;
         rd_ptr_next    = '0;
         count_next     = '0;
         msg_count_next = '0;
      end else begin
         if (wr) wr_ptr_next = wr_ptr_reg + 1'b1;
         if (rd) rd_ptr_next = rd_ptr_reg + 1'b1;
         case ({wr, rd})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
         endcase
         case ({wr & din_last, rd & dout_last})
            2'b10:   msg_count_next = msg_count_reg + 1'b1;
            2'b01:   msg_count_next = msg_count_reg - 1'b1;
            default: msg_count_next = msg_count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      msg_count_reg <= msg_count_next;
   end

   assign count     = count_reg;
   assign msg_count = msg_count_reg;
   assign msg_avail = (msg_count_reg != '0);

endmodule
